// File: rtl/serial_prom_emu_if.sv
// serial_prom_emu_if: pin-level bundle of the serial configuration-PROM bus.
// The master drives clock, address reset and chip enable; the PROM answers on data.
interface serial_prom_emu_if;
    logic prom_clk;
    logic prom_n_reset;
    logic prom_n_ce;
    logic prom_data;
    logic prom_data_oe;

    modport master (
        output prom_clk,
        output prom_n_reset,
        output prom_n_ce,
        input  prom_data,
        input  prom_data_oe
    );

    modport slave (
        input  prom_clk,
        input  prom_n_reset,
        input  prom_n_ce,
        output prom_data,
        output prom_data_oe
    );
endinterface

// File: rtl/serial_prom_emu.sv
// serial_prom_emu: emulated serial configuration PROM with a byte preload port.
// Build option PROM_MSB_FIRST_EN: emit each byte MSB first (default LSB first).
module serial_prom_emu #(
    parameter int ADDR_W      = 11,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk12m,
    input  logic              reset,
    serial_prom_emu_if.slave  prom,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              busy,
    output logic [ADDR_W-1:0] byte_count,
    output logic              wrapped
);
    typedef enum logic [1:0] {DISABLED, ARMED, STREAM} state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] nrst_sync;
    logic [SYNC_STAGES-1:0] nce_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   nrst_s;
    logic                   nce_s;
    logic                   clk_rise;
    logic [7:0]             mem [2**ADDR_W];
    logic [7:0]             rd_q;
    logic [7:0]             shreg;
    logic [7:0]             shreg_sh;
    logic [ADDR_W-1:0]      rd_addr;
    logic                   rd_en;
    logic                   armed_rd;
    logic                   out_bit;
    logic [2:0]             bit_idx;

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign nrst_s   = nrst_sync[SYNC_STAGES-1];
    assign nce_s    = nce_sync[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_prev;

`ifdef PROM_MSB_FIRST_EN
    assign out_bit  = shreg[7];
    assign shreg_sh = {shreg[6:0], 1'b0};
`else
    assign out_bit  = shreg[0];
    assign shreg_sh = {1'b0, shreg[7:1]};
`endif

    // Resynchronise the master pins; chains idle at clk low, address reset, deselected.
    always_ff @(posedge clk12m or posedge reset) begin
        if (reset) begin
            clk_sync  <= '0;
            nrst_sync <= '0;
            nce_sync  <= '1;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], prom.prom_clk};
            nrst_sync <= {nrst_sync[SYNC_STAGES-2:0], prom.prom_n_reset};
            nce_sync  <= {nce_sync[SYNC_STAGES-2:0], prom.prom_n_ce};
            clk_prev  <= clk_s;
        end
    end

    // State register.
    always_ff @(posedge clk12m or posedge reset) begin
        if (reset) state <= DISABLED;
        else       state <= state_nx;
    end

    // Next state and RAM read request; chip enable outranks address reset.
    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        rd_addr  = byte_count + ADDR_W'(1);
        unique case (state)
            DISABLED: begin
                if (!nce_s) state_nx = nrst_s ? STREAM : ARMED;
            end
            ARMED: begin
                rd_en   = 1'b1;
                rd_addr = '0;
                if (nce_s)                  state_nx = DISABLED;
                else if (nrst_s && armed_rd) state_nx = STREAM;
            end
            STREAM: begin
                rd_en = 1'b1;
                if (nce_s)        state_nx = DISABLED;
                else if (!nrst_s) state_nx = ARMED;
            end
            default: state_nx = DISABLED;
        endcase
    end

    assign busy              = (state != DISABLED);
    assign prom.prom_data_oe = (state == STREAM);
    assign prom.prom_data    = (state == STREAM) ? out_bit : 1'b1;

    // Byte store: preload only while idle; the read port keeps the next byte ready.
    always_ff @(posedge clk12m) begin
        if (wr_en && !busy) mem[wr_addr] <= wr_data;
        if (rd_en)          rd_q <= mem[rd_addr];
    end

    // Read position and shifter: restart at byte 0 when armed, advance per master edge.
    always_ff @(posedge clk12m or posedge reset) begin
        if (reset) begin
            shreg      <= '1;
            bit_idx    <= '0;
            byte_count <= '0;
            wrapped    <= 1'b0;
            armed_rd   <= 1'b0;
        end else begin
            armed_rd <= (state == ARMED);
            if (state == ARMED) begin
                byte_count <= '0;
                bit_idx    <= '0;
                wrapped    <= 1'b0;
                if (armed_rd) shreg <= rd_q;
            end else if (state == STREAM && !nce_s && nrst_s && clk_rise) begin
                bit_idx <= bit_idx + 3'd1;
                if (bit_idx == 3'd7) begin
                    shreg      <= rd_q;
                    byte_count <= byte_count + ADDR_W'(1);
                    if (&byte_count) wrapped <= 1'b1;
                end else begin
                    shreg <= shreg_sh;
                end
            end
        end
    end
endmodule

// File: doc/serial_prom_emu.md
Name: serial_prom_emu

Overview:
- Responder end of the serial configuration-PROM interface: emulates the PROM and shifts stored bytes out one bit per master clock.
- Master drives n_ce, n_reset and a slow clock (about 500 kHz); the block answers on a single data line.
- Contents are preloaded through a byte write port, typically fed by a UART receiver, before the master starts reading.
- Sits behind the FPGA pins and lets the PROM dump path be tested without real silicon.

Parameters:
ADDR_W, 11, byte address width; capacity 2^ADDR_W bytes
SYNC_STAGES, 2, flip-flop stages on each asynchronous PROM input, minimum 2

Ports:
clk12m  in  1  system clock, 12 MHz
reset  in  1  asynchronous, active-high reset
prom_clk  in  1  master serial clock, asynchronous
prom_n_reset  in  1  master address reset, active low, asynchronous
prom_n_ce  in  1  chip enable, active low, asynchronous
prom_data  out  1  serial data bit
prom_data_oe  out  1  output enable for the tri-state pad
wr_en  in  1  preload write strobe
wr_addr  in  ADDR_W  preload byte address
wr_data  in  8  preload byte
busy  out  1  high whenever state is not DISABLED; writes are ignored while high
byte_count  out  ADDR_W  current read byte address
wrapped  out  1  sticky: address wrapped past 2^ADDR_W-1

Behaviour:
- Reset values: prom_data=1, prom_data_oe=0, busy=0, byte_count=0, wrapped=0, bit index=0, state=DISABLED.
- Synchroniser chains reset to the inactive values: clk=0, n_reset=0, n_ce=1.
- Memory: 2^ADDR_W x 8 synchronous RAM, one-cycle read latency. Contents are not cleared by reset.
- wr_en is accepted only when busy=0.
- Edge detect: a rising edge of prom_clk is one clk12m cycle in which the synchronised clk is 1 and its previous value was 0.
- State DISABLED (sync n_ce=1):
  - prom_data_oe=0.
  - Address and bit index are held.
  - Go to ARMED when n_ce=0 and n_reset=0.
  - Go to STREAM when n_ce=0 and n_reset=1; this resumes the read at the held position.
- State ARMED (n_ce=0, n_reset=0):
  - prom_data_oe=0; byte_count=0; bit index=0; wrapped=0.
  - Issue a RAM read of byte 0 and load the shift register on the following cycle.
  - Go to STREAM when n_reset=1 and the shift register is loaded.
  - If n_reset=1 before the load completes, enter STREAM once the load lands, at most 2 cycles later.
- State STREAM:
  - prom_data_oe=1; prom_data = shift register bit 0.
  - On each rising edge of prom_clk: shift right and increment bit index.
  - When bit index reaches 7 and is then incremented: bit index wraps to 0, byte_count increments and the prefetched next byte is loaded.
  - Prefetch read of byte_count+1 is issued when bit index=0, so the next byte is ready long before bit 7 completes.
  - byte_count wraps from 2^ADDR_W-1 to 0 and sets wrapped.
  - n_ce going to 1 returns to DISABLED within SYNC_STAGES+1 cycles.
  - n_reset going to 0 while n_ce=0 returns to ARMED, which restarts from byte 0.
- Latency: prom_data changes no later than SYNC_STAGES+2 clk12m cycles after the prom_clk rising edge at the pin. This is well inside the master's 2 µs bit period.
- Simultaneous events:
  - n_ce and n_reset changing in the same cycle: n_ce takes priority.
  - A prom_clk edge in the same cycle as n_reset going low is ignored.
- reset asserted mid-stream: everything returns to reset values immediately, prom_data_oe drops asynchronously, and RAM contents are kept.

Optional Feature:
- Macro PROM_MSB_FIRST_EN.
- Defined: each byte is emitted MSB first; prom_data = shift register bit 7 and the register shifts left.
- Undefined (default): LSB first, as the PROM dumper expects.
- Byte sequencing, prefetch timing and all counters are identical in both builds.

Test Plan:
- Preload 0x00=0xA5, 0x01=0x3C; n_ce=0, n_reset low 4 µs then high; 16 prom_clk pulses at 500 kHz -> sampled bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; byte_count=2.
- wr_en with addr 0x10, data 0xFF while in STREAM -> write ignored, RAM[0x10] unchanged; same write in DISABLED -> accepted.
- ADDR_W=3, fill bytes 0..7, clock 66 bits -> byte_count=0, wrapped=1, and bits 65..66 come from byte 0 again.
- Raise n_ce after 12 bits, hold 20 µs, lower it with n_reset=1 -> bit 13 resumes at byte 1, bit 4; prom_data_oe=0 during the gap.
- Assert reset mid-byte -> prom_data_oe=0 and byte_count=0 immediately; a new n_reset sequence reads byte 0 correctly.
- With PROM_MSB_FIRST_EN defined, byte 0xA5 -> bits 1,0,1,0,0,1,0,1 (MSB first); byte 0x3C -> bits 0,0,1,1,1,1,0,0.
